// File: rtl/fw_tile_feeder.sv
// rtl/fw_tile_feeder.sv - packs row-major 16-bit elements into 64-bit words for the fw tile engine
// and sequences the per-phase word count for each tile.
module fw_tile_feeder #(
  parameter int DW    = 16,
  parameter int LANES = 4,
  parameter int N     = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          cfg_phase,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [DW-1:0]       s_data,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic                inhibit,
  output logic [DW*LANES-1:0] fw_in,
  output logic                fw_valid,
  output logic [1:0]          fw_phase,
  output logic                busy,
  output logic                tile_done
);

  localparam int WPB = N * N / LANES;
  localparam int LW  = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CW  = $clog2(3 * WPB + 1);
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  state_t               state;
  logic [LW-1:0]        lc;
  logic                 full;
  logic [DW*LANES-1:0]  pack;
  logic [CW-1:0]        wcnt;
  logic [CW-1:0]        fcnt;
  logic [CW-1:0]        target;

  logic issue;
  logic take;
  logic cfg_take;
  logic last_elem;
  logic last_word;

  // Phases 01 and 10 both need two blocks per tile.
  function automatic logic [CW-1:0] word_target(input logic [1:0] ph);
    logic [CW-1:0] t;
    case (ph)
      2'b00:   t = CW'(WPB);
      2'b11:   t = CW'(3 * WPB);
      default: t = CW'(2 * WPB);
    endcase
    return t;
  endfunction

  assign issue     = full && !inhibit;
  assign s_ready   = reset && (state == STREAM) && (!full || !inhibit);
  assign cfg_ready = reset && (state == IDLE);
  assign busy      = (state != IDLE);
  assign take      = s_valid && s_ready;
  assign cfg_take  = cfg_valid && cfg_ready;
  assign last_elem = take && (lc == LAST_LANE) && (fcnt == target - CW'(1));
  assign last_word = issue && (wcnt == target - CW'(1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      lc        <= '0;
      full      <= 1'b0;
      pack      <= '0;
      wcnt      <= '0;
      fcnt      <= '0;
      target    <= '0;
      fw_in     <= '0;
      fw_valid  <= 1'b0;
      fw_phase  <= 2'b00;
      tile_done <= 1'b0;
    end else begin
      fw_valid  <= 1'b0;
      tile_done <= 1'b0;

      if (issue) begin
        fw_in    <= pack;
        fw_valid <= 1'b1;
        full     <= 1'b0;
        wcnt     <= wcnt + CW'(1);
      end

      // A lane-0 element can land in the same cycle the previous word issues;
      // fw_in captures the pre-edge pack contents, so nothing is overwritten early.
      if (take) begin
        for (int i = 0; i < LANES; i++) begin
          if (lc == LW'(i)) pack[i*DW +: DW] <= s_data;
        end
        if (lc == LAST_LANE) begin
          lc   <= '0;
          full <= 1'b1;
          fcnt <= fcnt + CW'(1);
        end else begin
          lc <= lc + LW'(1);
        end
      end

      case (state)
        IDLE: begin
          if (cfg_take) begin
            fw_phase <= cfg_phase;
            target   <= word_target(cfg_phase);
            wcnt     <= '0;
            fcnt     <= '0;
            lc       <= '0;
            state    <= STREAM;
          end
        end
        STREAM: begin
          if (last_elem) state <= FLUSH;
        end
        FLUSH: begin
          if (last_word) begin
            tile_done <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
